button_conditioner: RTL and testbench

Conditions the raw active-low push-buttons of the catch-the-egg board before they reach the game core. Each channel gets a two-flop synchronizer, a counter-based debouncer, a one-cycle press pulse and optional hold-to-repeat. The outputs replace the game's ad-hoc resync shift registers: `PRESS[0]` moves the bucket right, `PRESS[1]` moves it left, and `PRESS[2]` restarts the game.

---
 rtl/button_conditioner.sv | 159 +++++++++++++++
 tb/tb_button_conditioner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronizer, counter debouncer, press/release
// pulse generator and optional hold-to-repeat for active-low push-buttons.
// All outputs come straight from flops; there is no combinational path from BTN_N.
module button_conditioner #(
    parameter int unsigned        NUM_BTN         = 3,
    parameter int unsigned        CNT_W           = 23,
    parameter int unsigned        DEBOUNCE_CYCLES = 240000,
    parameter int unsigned        REPEAT_DELAY    = 4800000,
    parameter int unsigned        REPEAT_PERIOD   = 1200000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 3'b011
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_BTN-1:0] BTN_N,
    output logic [NUM_BTN-1:0] PRESS,
    output logic [NUM_BTN-1:0] RELEASE,
    output logic [NUM_BTN-1:0] LEVEL
);

    // Largest count a CNT_W-bit counter can represent, plus one.
    localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

    // Elaboration-time parameter range checks.
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("button_conditioner: CNT_W must be in 1..32");
    end
    if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > CNT_SPAN) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES out of range 1..2^CNT_W");
    end
    if (REPEAT_DELAY < 1 || 64'(REPEAT_DELAY) > CNT_SPAN) begin : g_bad_delay
        $error("button_conditioner: REPEAT_DELAY out of range 1..2^CNT_W");
    end
    if (REPEAT_PERIOD < 1 || 64'(REPEAT_PERIOD) > CNT_SPAN) begin : g_bad_period
        $error("button_conditioner: REPEAT_PERIOD out of range 1..2^CNT_W");
    end

    // Terminal counts; counters run 0..N-1 so they never wrap.
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    // Two-flop synchronizer; stores the active-high pressed level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~BTN_N;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] rep_q;
        logic             first_q;
        logic             press_q;
        logic             release_q;
        logic             level_q;

        logic             s;
        logic [CNT_W-1:0] cnt_inc_d;
        logic [CNT_W-1:0] rep_inc_d;
        logic [CNT_W-1:0] rep_last_d;

        assign s = sync2_q[i];

        // Counter increments and the active repeat terminal count.
        // first_q selects between the initial delay and the steady period,
        // standing in for a full-width limit register.
        always_comb begin
            cnt_inc_d  = cnt_q + 1'b1;
            rep_inc_d  = rep_q + 1'b1;
            rep_last_d = first_q ? DELAY_LAST : PERIOD_LAST;
        end

        // Debounce / repeat FSM with registered pulse and level outputs.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                rep_q     <= '0;
                first_q   <= 1'b1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                level_q   <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        level_q <= 1'b0;
                        if (s) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s) begin
                            state_q <= IDLE;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= HELD;
                            press_q <= 1'b1;
                            level_q <= 1'b1;
                            rep_q   <= '0;
                            first_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= '0;
                        end else if (REPEAT_MASK[i]) begin
                            if (rep_q == rep_last_d) begin
                                press_q <= 1'b1;
                                rep_q   <= '0;
                                first_q <= 1'b0;
                            end else begin
                                rep_q <= rep_inc_d;
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s) begin
                            state_q <= HELD;
                        end else if (cnt_q == DB_LAST) begin
                            state_q   <= IDLE;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end

        assign PRESS[i]   = press_q;
        assign RELEASE[i] = release_q;
        assign LEVEL[i]   = level_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: vector table, hand-written
// corner sequences and a randomized run against a run-length reference model.
module tb_button_conditioner;

    localparam int NB = 3;
    localparam int CW = 8;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [2:0] RM = 3'b011;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [2:0] BTN_N;
    logic [2:0] PRESS;
    logic [2:0] RELEASE;
    logic [2:0] LEVEL;

    always #5 CLK = ~CLK;

    button_conditioner #(
        .NUM_BTN        (NB),
        .CNT_W          (CW),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (RM)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .BTN_N  (BTN_N),
        .PRESS  (PRESS),
        .RELEASE(RELEASE),
        .LEVEL  (LEVEL)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a channel's debounced level flips once the synced level
    // has disagreed with it on DB+1 consecutive edges; repeat age counts edges
    // of uninterrupted holding after the press.
    bit [2:0] m_s1, m_s2, m_prev, m_level, m_press, m_rel;
    int       m_run [3];
    int       m_age [3];

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_prev = '0; m_level = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
    endtask

    task automatic model_edge();
        if (!RST_N) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit s;
                s = m_s2[i];
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                if (s != m_level[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DB + 1) begin
                    m_level[i] = s;
                    m_run[i]   = 0;
                    if (s) begin
                        m_press[i] = 1'b1;
                        m_age[i]   = 0;
                    end else begin
                        m_rel[i] = 1'b1;
                    end
                end else if (m_level[i] && s && m_prev[i] && RM[i]) begin
                    m_age[i]++;
                    if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0))
                        m_press[i] = 1'b1;
                end
                m_prev[i] = s;
            end
            m_s2 = m_s1;
            m_s1 = ~BTN_N;
        end
    endtask

    // One clock: DUT and model advance on the rising edge, compare on the falling edge.
    task automatic tick(input string tag);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check({tag, " PRESS"}, PRESS, m_press);
        check({tag, " RELEASE"}, RELEASE, m_rel);
        check({tag, " LEVEL"}, LEVEL, m_level);
    endtask

    task automatic idle(input int n);
        BTN_N = 3'b111;
        for (int k = 0; k < n; k++) tick("idle");
    endtask

    typedef struct {
        logic [2:0] btn_n;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] level;
    } vec_t;

    vec_t vecs [28];

    int         cnt;
    logic [2:0] exp3;
    int         dur [3];
    logic [2:0] rnd_btn;

    initial begin
        // Vectors 0..15: clean press on channel 0, low 8 cycles.
        for (int k = 0; k < 16; k++) begin
            vecs[k].btn_n = (k < 8) ? 3'b110 : 3'b111;
            vecs[k].press = (k == 6) ? 3'b001 : 3'b000;
            vecs[k].rel   = (k == 14) ? 3'b001 : 3'b000;
            vecs[k].level = (k >= 6 && k < 14) ? 3'b001 : 3'b000;
        end
        // Vectors 16..27: bouncing channel 1 (low 3, high 1, low 2, high).
        for (int k = 16; k < 28; k++) begin
            vecs[k].btn_n = ((k >= 16 && k <= 18) || k == 20 || k == 21) ? 3'b101 : 3'b111;
            vecs[k].press = 3'b000;
            vecs[k].rel   = 3'b000;
            vecs[k].level = 3'b000;
        end

        BTN_N = 3'b111;
        RST_N = 1'b0;
        model_reset();
        tick("reset");
        tick("reset");
        RST_N = 1'b1;
        idle(3);

        // Table-driven clean press and bounce rejection.
        for (int k = 0; k < 28; k++) begin
            BTN_N = vecs[k].btn_n;
            tick("vec");
            check("vec press", PRESS, vecs[k].press);
            check("vec release", RELEASE, vecs[k].rel);
            check("vec level", LEVEL, vecs[k].level);
        end
        idle(3);

        // Long hold on channel 0 (repeats) and channel 2 (no repeat).
        for (int k = 0; k < 40; k++) begin
            BTN_N = (k < 30) ? 3'b010 : 3'b111;
            tick("hold");
            exp3 = '0;
            exp3[0] = (k == 6) || (k >= 16 && k <= 31 && (k - 16) % 3 == 0);
            check("hold ch0 press", {2'b00, PRESS[0]}, exp3);
            exp3[0] = (k == 6);
            check("hold ch2 press", {2'b00, PRESS[2]}, exp3);
        end
        idle(3);

        // Short bounce-back while held: level stays, no release, repeats resume.
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            BTN_N = (k < 20 || (k >= 22 && k < 40)) ? 3'b110 : 3'b111;
            tick("bounceback");
            if (k >= 20 && k < 36) begin
                check("bounceback level", {2'b00, LEVEL[0]}, 3'b001);
                check("bounceback release", {2'b00, RELEASE[0]}, 3'b000);
            end
            if (k >= 22 && k < 40 && PRESS[0]) cnt++;
        end
        check("bounceback repeats resumed", {2'b00, (cnt > 0)}, 3'b001);
        idle(3);

        // Simultaneous press on channels 0 and 1.
        for (int k = 0; k < 20; k++) begin
            BTN_N = (k < 10) ? 3'b100 : 3'b111;
            tick("simul");
            check("simul press", PRESS, (k == 6) ? 3'b011 : 3'b000);
        end
        idle(3);

        // Asynchronous reset in the middle of auto-repeat, button still held.
        BTN_N = 3'b110;
        for (int k = 0; k < 20; k++) tick("prerst");
        check("prerst level", LEVEL, 3'b001);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check("async rst press", PRESS, 3'b000);
        check("async rst release", RELEASE, 3'b000);
        check("async rst level", LEVEL, 3'b000);
        tick("in reset");
        tick("in reset");
        RST_N = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick("postrst");
            check("postrst press", PRESS, (k == 6) ? 3'b001 : 3'b000);
        end
        idle(12);

        // Randomized holds of varying length, with occasional resets.
        rnd_btn = 3'b111;
        for (int i = 0; i < 3; i++) dur[i] = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (dur[i] == 0) begin
                    rnd_btn[i] = 1'($urandom_range(0, 1));
                    dur[i] = (($urandom_range(0, 3) == 0)) ? int'($urandom_range(10, 40))
                                                          : int'($urandom_range(1, 8));
                end
                dur[i]--;
            end
            BTN_N = rnd_btn;
            RST_N = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick("random");
        end
        RST_N = 1'b1;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
